// File: rtl/multi_edge_counter.sv
// rtl/multi_edge_counter.sv - multi-channel synchronised edge counter with saturation and atomic snapshot
`timescale 1ns/1ps
module multi_edge_counter #(
  parameter int N_CH         = 4,
  parameter int CNT_W        = 16,
  parameter int SYNC_STAGES  = 2,
  parameter bit CLR_ON_DIS   = 1'b1,
  parameter bit CLR_ON_LATCH = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic [2*N_CH-1:0]     mode,
  input  logic [N_CH-1:0]       in,
  input  logic                  latch,
  output logic [N_CH*CNT_W-1:0] cnt_live,
  output logic [N_CH*CNT_W-1:0] cnt_snap,
  output logic [N_CH-1:0]       ovf,
  output logic [N_CH-1:0]       ovf_snap,
  output logic                  snap_valid
);

  localparam int                ARM_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0]  ARM_DONE = ARM_W'(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  logic [SYNC_STAGES-1:0] sync_q [N_CH];
  logic [N_CH-1:0]        sync_out;
  logic [N_CH-1:0]        prev_q;
  logic [N_CH-1:0]        rise_vec;
  logic [N_CH-1:0]        fall_vec;
  logic [N_CH-1:0]        edge_det;
  logic [ARM_W-1:0]       arm_cnt;
  logic                   armed;

  assign armed    = (arm_cnt == ARM_DONE);
  assign rise_vec = sync_out & ~prev_q;
  assign fall_vec = ~sync_out & prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) sync_q[i] <= '0;
      prev_q  <= '0;
      arm_cnt <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], in[i]};
      prev_q <= sync_out;
      // Arm counter keeps the first samples after reset from being seen as edges
      if (!armed) arm_cnt <= arm_cnt + 1'b1;
    end
  end

  always_comb begin
    sync_out = '0;
    for (int i = 0; i < N_CH; i++) sync_out[i] = sync_q[i][SYNC_STAGES-1];
  end

  always_comb begin
    edge_det = '0;
    for (int i = 0; i < N_CH; i++) begin
      case (mode[2*i +: 2])
        2'b00:   edge_det[i] = rise_vec[i];
        2'b01:   edge_det[i] = fall_vec[i];
        2'b10:   edge_det[i] = rise_vec[i] | fall_vec[i];
        default: edge_det[i] = 1'b0;
      endcase
    end
    if (!armed) edge_det = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_live   <= '0;
      ovf        <= '0;
      cnt_snap   <= '0;
      ovf_snap   <= '0;
      snap_valid <= 1'b0;
    end else begin
      snap_valid <= latch;
      // Snapshot sees the pre-update live values of every channel in the same cycle
      if (latch) begin
        cnt_snap <= cnt_live;
        ovf_snap <= ovf;
      end
      for (int i = 0; i < N_CH; i++) begin
        if (clr) begin
          cnt_live[i*CNT_W +: CNT_W] <= '0;
          ovf[i]                     <= 1'b0;
        end else if (!en) begin
          if (CLR_ON_DIS) begin
            cnt_live[i*CNT_W +: CNT_W] <= '0;
            ovf[i]                     <= 1'b0;
          end
        end else if (CLR_ON_LATCH && latch) begin
          cnt_live[i*CNT_W +: CNT_W] <= CNT_W'(edge_det[i]);
          ovf[i]                     <= 1'b0;
        end else if (edge_det[i]) begin
          if (cnt_live[i*CNT_W +: CNT_W] != CNT_MAX)
            cnt_live[i*CNT_W +: CNT_W] <= cnt_live[i*CNT_W +: CNT_W] + CNT_W'(1);
          else
            ovf[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_edge_counter.sv
// tb/tb_multi_edge_counter.sv - bench for multi_edge_counter, default and narrow/latch-clear instances
`timescale 1ns/1ps
module tb_multi_edge_counter;

  localparam int N  = 4;
  localparam int WA = 16;
  localparam int WB = 4;
  localparam int SW = N*WA + N + N*WB + N;

  typedef logic [SW-1:0] snap_t;

  logic            clk = 1'b0;
  logic            rst_n, en, clr, latch;
  logic [2*N-1:0]  mode;
  logic [N-1:0]    in;
  logic [N*WA-1:0] live_a, snap_a;
  logic [N*WB-1:0] live_b, snap_b;
  logic [N-1:0]    ovf_a, ovf_snap_a, ovf_b, ovf_snap_b;
  logic            sv_a, sv_b;

  int    n_checks = 0;
  int    n_fail   = 0;
  snap_t sb_q[$];
  snap_t exp_s;

  always #5 clk = ~clk;

  multi_edge_counter #(.N_CH(N), .CNT_W(WA), .SYNC_STAGES(2), .CLR_ON_DIS(1'b1), .CLR_ON_LATCH(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode), .in(in), .latch(latch),
    .cnt_live(live_a), .cnt_snap(snap_a), .ovf(ovf_a), .ovf_snap(ovf_snap_a), .snap_valid(sv_a));

  multi_edge_counter #(.N_CH(N), .CNT_W(WB), .SYNC_STAGES(2), .CLR_ON_DIS(1'b0), .CLR_ON_LATCH(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode), .in(in), .latch(latch),
    .cnt_live(live_b), .cnt_snap(snap_b), .ovf(ovf_b), .ovf_snap(ovf_snap_b), .snap_valid(sv_b));

  function automatic logic [N*WA-1:0] pk_a(input int c3, input int c2, input int c1, input int c0);
    return {WA'(c3), WA'(c2), WA'(c1), WA'(c0)};
  endfunction

  function automatic logic [N*WB-1:0] pk_b(input int c3, input int c2, input int c1, input int c0);
    return {WB'(c3), WB'(c2), WB'(c1), WB'(c0)};
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic [N-1:0] m, input int hi, input int lo);
    in = in | m;
    cyc(hi);
    in = in & ~m;
    cyc(lo);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
  endtask

  task automatic test_reset();
    in = '0; en = 1'b1; clr = 1'b0; latch = 1'b0; mode = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    cyc(2);
    n_checks++;
    if ({live_a, snap_a, ovf_a, ovf_snap_a, sv_a} !== '0) begin
      n_fail++; $display("FAIL reset_a: got %h expected 0", {live_a, snap_a, ovf_a, ovf_snap_a, sv_a});
    end
    n_checks++;
    if ({live_b, snap_b, ovf_b, ovf_snap_b, sv_b} !== '0) begin
      n_fail++; $display("FAIL reset_b: got %h expected 0", {live_b, snap_b, ovf_b, ovf_snap_b, sv_b});
    end
    rst_n = 1'b1;
    cyc(5);
  endtask

  task automatic test_rising();
    do_clr();
    mode = '0;
    repeat (4) pulse(4'b0001, 4, 4);
    in[0] = 1'b1;
    cyc(2);
    n_checks++;
    if (live_a !== pk_a(0, 0, 0, 4)) begin
      n_fail++; $display("FAIL rise_latency_early: got %h expected %h", live_a, pk_a(0, 0, 0, 4));
    end
    cyc(1);
    n_checks++;
    if (live_a !== pk_a(0, 0, 0, 5)) begin
      n_fail++; $display("FAIL rise_latency: got %h expected %h", live_a, pk_a(0, 0, 0, 5));
    end
    in[0] = 1'b0;
    cyc(4);
    n_checks++;
    if (live_b !== pk_b(0, 0, 0, 5)) begin
      n_fail++; $display("FAIL rise_b: got %h expected %h", live_b, pk_b(0, 0, 0, 5));
    end
  endtask

  task automatic test_modes();
    do_clr();
    mode = 8'b11_01_10_00;
    repeat (3) pulse(4'b1110, 4, 4);
    n_checks++;
    if (live_a !== pk_a(0, 3, 6, 0)) begin
      n_fail++; $display("FAIL modes_a: got %h expected %h", live_a, pk_a(0, 3, 6, 0));
    end
    n_checks++;
    if (live_b !== pk_b(0, 3, 6, 0)) begin
      n_fail++; $display("FAIL modes_b: got %h expected %h", live_b, pk_b(0, 3, 6, 0));
    end
    // rise on a falling-mode channel, then a mode switch while high: neither counts
    in[2] = 1'b1;
    cyc(4);
    mode = 8'b11_00_00_00;
    cyc(4);
    in[2] = 1'b0;
    cyc(4);
    n_checks++;
    if (live_a !== pk_a(0, 3, 6, 0)) begin
      n_fail++; $display("FAIL mode_switch: got %h expected %h", live_a, pk_a(0, 3, 6, 0));
    end
    mode = '0;
  endtask

  task automatic test_saturation();
    do_clr();
    mode = '0;
    for (int i = 1; i <= 17; i++) begin
      pulse(4'b0001, 2, 2);
      if (i >= 15) begin
        n_checks++;
        if ({live_b, ovf_b} !== {pk_b(0, 0, 0, 15), 3'b000, (i >= 16)}) begin
          n_fail++; $display("FAIL sat_b edge %0d: got %h expected %h", i, {live_b, ovf_b},
                             {pk_b(0, 0, 0, 15), 3'b000, (i >= 16)});
        end
      end
    end
    n_checks++;
    if ({live_a, ovf_a} !== {pk_a(0, 0, 0, 17), 4'b0000}) begin
      n_fail++; $display("FAIL sat_a: got %h expected %h", {live_a, ovf_a}, {pk_a(0, 0, 0, 17), 4'b0000});
    end
    sb_q.push_back({pk_a(0, 0, 0, 17), 4'b0000, pk_b(0, 0, 0, 15), 4'b0001});
    latch = 1'b1;
    cyc(1);
    latch = 1'b0;
    n_checks++;
    if (sv_a !== 1'b1 || sv_b !== 1'b1 || sb_q.size() == 0) begin
      n_fail++; $display("FAIL sat_snap_valid: got %b%b expected 11", sv_a, sv_b);
    end else begin
      exp_s = sb_q.pop_front();
      n_checks++;
      if ({snap_a, ovf_snap_a, snap_b, ovf_snap_b} !== exp_s) begin
        n_fail++; $display("FAIL sat_snap: got %h expected %h", {snap_a, ovf_snap_a, snap_b, ovf_snap_b}, exp_s);
      end
    end
    n_checks++;
    if ({live_b, ovf_b} !== '0) begin
      n_fail++; $display("FAIL sat_latch_clear_b: got %h expected 0", {live_b, ovf_b});
    end
    do_clr();
    n_checks++;
    if ({live_a, ovf_a} !== '0) begin
      n_fail++; $display("FAIL sat_clr_a: got %h expected 0", {live_a, ovf_a});
    end
  endtask

  task automatic test_snapshot();
    do_clr();
    mode = '0;
    repeat (7) pulse(4'b0001, 4, 4);
    repeat (2) pulse(4'b0010, 4, 4);
    // latch lands in the same cycle as the 8th ch0 edge is detected
    sb_q.push_back({pk_a(0, 0, 2, 7), 4'b0000, pk_b(0, 0, 2, 7), 4'b0000});
    in[0] = 1'b1;
    cyc(2);
    latch = 1'b1;
    cyc(1);
    latch = 1'b0;
    n_checks++;
    if (sv_a !== 1'b1 || sv_b !== 1'b1 || sb_q.size() == 0) begin
      n_fail++; $display("FAIL snap_valid: got %b%b expected 11", sv_a, sv_b);
    end else begin
      exp_s = sb_q.pop_front();
      n_checks++;
      if ({snap_a, ovf_snap_a, snap_b, ovf_snap_b} !== exp_s) begin
        n_fail++; $display("FAIL snap_coincident: got %h expected %h", {snap_a, ovf_snap_a, snap_b, ovf_snap_b}, exp_s);
      end
    end
    n_checks++;
    if ({live_a, live_b} !== {pk_a(0, 0, 2, 8), pk_b(0, 0, 0, 1)}) begin
      n_fail++; $display("FAIL live_after_latch: got %h expected %h", {live_a, live_b},
                         {pk_a(0, 0, 2, 8), pk_b(0, 0, 0, 1)});
    end
    cyc(1);
    n_checks++;
    if ({sv_a, sv_b} !== 2'b00) begin
      n_fail++; $display("FAIL snap_valid_pulse: got %b%b expected 00", sv_a, sv_b);
    end
    in[0] = 1'b0;
    cyc(4);
  endtask

  task automatic test_back_to_back();
    pulse(4'b0010, 4, 4);
    sb_q.push_back({pk_a(0, 0, 3, 8), 4'b0000, pk_b(0, 0, 1, 1), 4'b0000});
    sb_q.push_back({pk_a(0, 0, 3, 8), 4'b0000, pk_b(0, 0, 0, 0), 4'b0000});
    latch = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cyc(1);
      if (k == 1) latch = 1'b0;
      n_checks++;
      if (sv_a !== 1'b1 || sv_b !== 1'b1 || sb_q.size() == 0) begin
        n_fail++; $display("FAIL b2b_valid %0d: got %b%b expected 11", k, sv_a, sv_b);
      end else begin
        exp_s = sb_q.pop_front();
        n_checks++;
        if ({snap_a, ovf_snap_a, snap_b, ovf_snap_b} !== exp_s) begin
          n_fail++; $display("FAIL b2b_snap %0d: got %h expected %h", k, {snap_a, ovf_snap_a, snap_b, ovf_snap_b}, exp_s);
        end
      end
    end
    // latch together with clr: snapshot keeps the pre-clear counts
    pulse(4'b0001, 4, 4);
    sb_q.push_back({pk_a(0, 0, 3, 9), 4'b0000, pk_b(0, 0, 0, 1), 4'b0000});
    latch = 1'b1;
    clr = 1'b1;
    cyc(1);
    latch = 1'b0;
    clr = 1'b0;
    n_checks++;
    if (sv_a !== 1'b1 || sb_q.size() == 0) begin
      n_fail++; $display("FAIL latch_clr_valid: got %b expected 1", sv_a);
    end else begin
      exp_s = sb_q.pop_front();
      n_checks++;
      if ({snap_a, ovf_snap_a, snap_b, ovf_snap_b} !== exp_s) begin
        n_fail++; $display("FAIL latch_clr_snap: got %h expected %h", {snap_a, ovf_snap_a, snap_b, ovf_snap_b}, exp_s);
      end
    end
    cyc(1);
    n_checks++;
    if ({live_a, live_b, snap_a} !== {pk_a(0, 0, 0, 0), pk_b(0, 0, 0, 0), pk_a(0, 0, 3, 9)}) begin
      n_fail++; $display("FAIL latch_clr_live: got %h expected %h", {live_a, live_b, snap_a},
                         {pk_a(0, 0, 0, 0), pk_b(0, 0, 0, 0), pk_a(0, 0, 3, 9)});
    end
  endtask

  task automatic test_enable();
    do_clr();
    repeat (3) pulse(4'b0001, 4, 4);
    en = 1'b0;
    cyc(2);
    repeat (2) pulse(4'b0001, 4, 4);
    n_checks++;
    if ({live_a, live_b} !== {pk_a(0, 0, 0, 0), pk_b(0, 0, 0, 3)}) begin
      n_fail++; $display("FAIL en_low: got %h expected %h", {live_a, live_b}, {pk_a(0, 0, 0, 0), pk_b(0, 0, 0, 3)});
    end
    en = 1'b1;
    cyc(2);
    pulse(4'b0001, 4, 4);
    n_checks++;
    if ({live_a, live_b} !== {pk_a(0, 0, 0, 1), pk_b(0, 0, 0, 4)}) begin
      n_fail++; $display("FAIL en_resume: got %h expected %h", {live_a, live_b}, {pk_a(0, 0, 0, 1), pk_b(0, 0, 0, 4)});
    end
  endtask

  task automatic test_arm();
    rst_n = 1'b0;
    in = 4'b0001;
    cyc(2);
    rst_n = 1'b1;
    cyc(8);
    n_checks++;
    if ({live_a, live_b} !== '0) begin
      n_fail++; $display("FAIL arm_held_high: got %h expected 0", {live_a, live_b});
    end
    in[0] = 1'b0;
    cyc(4);
    in[0] = 1'b1;
    cyc(4);
    n_checks++;
    if ({live_a, live_b} !== {pk_a(0, 0, 0, 1), pk_b(0, 0, 0, 1)}) begin
      n_fail++; $display("FAIL arm_first_rise: got %h expected %h", {live_a, live_b}, {pk_a(0, 0, 0, 1), pk_b(0, 0, 0, 1)});
    end
    in[0] = 1'b0;
    cyc(4);
  endtask

  task automatic test_reset_mid();
    do_clr();
    repeat (2) pulse(4'b0001, 4, 4);
    sb_q.push_back({pk_a(0, 0, 0, 2), 4'b0000, pk_b(0, 0, 0, 2), 4'b0000});
    latch = 1'b1;
    cyc(1);
    latch = 1'b0;
    n_checks++;
    if (sv_a !== 1'b1 || sb_q.size() == 0) begin
      n_fail++; $display("FAIL mid_snap_valid: got %b expected 1", sv_a);
    end else begin
      exp_s = sb_q.pop_front();
      n_checks++;
      if ({snap_a, ovf_snap_a, snap_b, ovf_snap_b} !== exp_s) begin
        n_fail++; $display("FAIL mid_snap: got %h expected %h", {snap_a, ovf_snap_a, snap_b, ovf_snap_b}, exp_s);
      end
    end
    in[0] = 1'b1;
    cyc(1);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({live_a, snap_a, ovf_a, ovf_snap_a, sv_a, live_b, snap_b, ovf_b, ovf_snap_b, sv_b} !== '0) begin
      n_fail++; $display("FAIL async_reset: got %h expected 0",
                         {live_a, snap_a, ovf_a, ovf_snap_a, sv_a, live_b, snap_b, ovf_b, ovf_snap_b, sv_b});
    end
    cyc(2);
    rst_n = 1'b1;
    cyc(6);
    in[0] = 1'b0;
    cyc(4);
    repeat (3) pulse(4'b0001, 4, 4);
    n_checks++;
    if ({live_a, live_b} !== {pk_a(0, 0, 0, 3), pk_b(0, 0, 0, 3)}) begin
      n_fail++; $display("FAIL resume_after_reset: got %h expected %h", {live_a, live_b}, {pk_a(0, 0, 0, 3), pk_b(0, 0, 0, 3)});
    end
  endtask

  initial begin
    test_reset();
    test_rising();
    test_modes();
    test_saturation();
    test_snapshot();
    test_back_to_back();
    test_enable();
    test_arm();
    test_reset_mid();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/multi_edge_counter.md
Name: multi_edge_counter

Overview:
- Multi-channel, parametrised edge counter for slow asynchronous status/trigger lines, e.g. discriminator or pulser monitor inputs.
- Per-channel input synchroniser and selectable edge mode (rising, falling, both, off).
- Counters saturate and raise a sticky overflow flag.
- An atomic snapshot latch lets firmware read all channels coherently, with optional clear-on-read.

Parameters:
N_CH, 4, number of independent channels
CNT_W, 16, counter width per channel
SYNC_STAGES, 2, synchroniser depth on each input (legal range 2-4)
CLR_ON_DIS, 1, 1: counters clear while en=0; 0: counters hold while en=0
CLR_ON_LATCH, 0, 1: latch also restarts live counters and ovf

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous assert, active-low
en  input  1  global count enable
clr  input  1  synchronous clear of live counters and ovf
mode  input  2*N_CH  per-channel edge select; ch i uses [2i+1:2i]: 00 rising, 01 falling, 10 both, 11 off
in  input  N_CH  asynchronous channel inputs
latch  input  1  single-cycle snapshot request
cnt_live  output  N_CH*CNT_W  live counts, ch i at [i*CNT_W +: CNT_W]
cnt_snap  output  N_CH*CNT_W  snapshot counts, same packing
ovf  output  N_CH  sticky live saturation flags
ovf_snap  output  N_CH  snapshot of ovf
snap_valid  output  1  one-cycle pulse, cycle after latch

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs are 0. Synchroniser flops, previous-value flops and arm counter are 0.
- Arming after reset release:
  - Edge detection is masked for the first SYNC_STAGES+1 clk edges.
  - An input held high through reset is therefore never counted as a rising edge.
- Synchroniser: SYNC_STAGES flops per channel. A previous-value flop follows the last stage.
- Edge definitions: rise = sync & ~prev; fall = ~sync & prev; both = rise | fall; off = 0.
- Latency: if in changes before clk edge k, cnt_live reflects it after edge k+SYNC_STAGES.
- Mode changes take effect on the next detection cycle. No edge is synthesised by the mode change itself.
- Minimum detectable pulse: one full clk period high and one low. Shorter pulses may be missed, and this is not flagged.
- Per-channel update priority, highest first:
  1. clr=1 -> cnt=0, ovf=0.
  2. en=0 -> cnt=0, ovf=0 if CLR_ON_DIS=1; otherwise hold.
  3. latch=1 with CLR_ON_LATCH=1 -> cnt = (edge ? 1 : 0), ovf = 0. The coincident edge is kept; no edge is lost.
  4. Edge with cnt < 2^CNT_W-1 -> cnt+1.
  5. Edge with cnt = 2^CNT_W-1 -> cnt holds at max, ovf <= 1.
- Saturation: no wrap-around. ovf stays set until clr, reset, en=0 (with CLR_ON_DIS=1) or latch (with CLR_ON_LATCH=1).
- Snapshot:
  - On latch=1, every channel's cnt_snap <= cnt_live and ovf_snap <= ovf, using pre-update register values. All channels are captured in the same cycle.
  - snap_valid=1 on the following cycle only.
  - Back-to-back latches each produce a pulse and a fresh capture.
- latch coinciding with clr: the snapshot takes the pre-clear values, then the live counters clear.
- cnt_snap and ovf_snap are unaffected by clr and en. Only reset or a new latch changes them.
- Reset mid-operation clears everything immediately and re-arms the mask.

Test Plan:
1. Defaults, mode=0, en=1: 5 rising pulses on in[0] (4 clk high / 4 clk low) -> cnt_live ch0=5 two clks after the last rise; ch1-3 = 0.
2. mode ch1=10, ch2=01, 3 full pulses on in[1] and in[2] -> ch1=6, ch2=3. Then ch3=11 with pulses -> ch3 stays 0.
3. CNT_W=4: 17 rising edges -> cnt=15, ovf[0]=1 from the 16th edge on; clr -> cnt=0, ovf=0.
4. Counts ch0=7, ch1=2; latch -> next cycle snap_valid=1, cnt_snap={..,2,7}. With CLR_ON_LATCH=1 and an edge on ch0 in the latch cycle -> snap ch0=7, live ch0=1.
5. in[0] held high across reset release, en=1 -> no count; first falling then rising transition -> cnt=1. Toggle en low with CLR_ON_DIS=0 -> count holds; with CLR_ON_DIS=1 -> 0.
6. Assert rst_n=0 mid-pulse-train with snapshot valid -> all outputs 0 asynchronously, and counting resumes correctly after the arm window.
